seven_segment_scanner: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It is the output-side counterpart of the push-button input conditioning path. A single-cycle `load` pulse, normally the conditioned button pulse, captures a 16-bit value. The block then scans the four hex digits onto the shared segment bus with a programmable refresh rate and an anti-ghosting blank interval.

---
 rtl/seven_segment_scanner.sv | 121 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-slot blanking.
// Optional leading-zero suppression is enabled by defining SSD_LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {StBlank, StShow} state_e;

    localparam state_e StReset = (BLANK_CYCLES == 0) ? StShow : StBlank;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    state_e          state_q, state_d;
    logic [15:0]     buf_val_q;
    logic [3:0]      buf_dp_q;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            wrap;
    logic [3:0]      nibble;
    logic            suppress;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state: slot counter, digit index and scan state track each other.
    always_comb begin
        wrap    = (cnt_q == CntW'(REFRESH_DIV - 1));
        cnt_d   = wrap ? '0 : cnt_q + CntW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        state_d = ((BLANK_CYCLES != 0) && (cnt_d < CntW'(BLANK_CYCLES))) ? StBlank : StShow;
    end

    always_comb begin
        nibble = buf_val_q[{idx_q, 2'b00} +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        unique case (idx_q)
            2'd3:    suppress = (buf_val_q[15:12] == 4'h0);
            2'd2:    suppress = (buf_val_q[15:8] == 8'h00);
            2'd1:    suppress = (buf_val_q[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif
    end

    // Outputs are computed from the current scan position and registered.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == StShow && !suppress) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(nibble);
            dp_d        = ~buf_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            state_q   <= StReset;
            buf_val_q <= 16'h0000;
            buf_dp_q  <= 4'h0;
            an_q      <= 4'b1111;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            if (load) begin
                buf_val_q <= value;
                buf_dp_q  <= dp_mask;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed and randomized-load bench for seven_segment_scanner (REFRESH_DIV=8, BLANK_CYCLES=2).
// Honors SSD_LEADING_ZERO_BLANK_EN to pick the expected leading-zero behaviour.
module tb_seven_segment_scanner;

    localparam int unsigned RDIV = 8;
    localparam int unsigned BLK  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int failures = 0;
    int pos = -1;

    logic [6:0] seg_tab [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_segment_scanner #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .value   (value),
        .dp_mask (dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (pos=%0d)", tag, got, exp, pos);
        end
    endtask

    // Inputs are sampled at the next rising edge; outputs are read on the falling edge.
    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] m);
        load    = ld;
        value   = v;
        dp_mask = m;
        @(negedge clk);
        pos++;
        load = 1'b0;
    endtask

    initial begin
        int c;
        int i;
        int show_cnt [4];
        logic [3:0]  e_an;
        logic [6:0]  dig_seg [4];
        logic [15:0] m_val;
        logic [3:0]  m_dp;
        logic [15:0] rv;
        logic [3:0]  rm;
        logic        rl;
        int v_onehot;
        int v_blank;
        int v_seg;
        bit found;

        // Reset held three cycles
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 16'h0, 4'h0);
            check_eq("rst_an", {12'h0, an}, 16'h000F);
            check_eq("rst_seg", {9'h0, seg}, 16'h007F);
            check_eq("rst_dp", {15'h0, dp}, 16'h0001);
        end
        reset = 1'b0;
        pos = -1;
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("rel_blank0", {12'h0, an}, 16'h000F);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("rel_blank1", {12'h0, an}, 16'h000F);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("rel_first_an", {12'h0, an}, 16'h000E);
        check_eq("rel_first_seg", {9'h0, seg}, 16'h0040);

        // Frame of 16'h12AF with dp on digit 2
        cycle(1'b1, 16'h12AF, 4'b0100);
        while (pos % 32 != 31) cycle(1'b0, 16'h0, 4'h0);
        dig_seg[0] = 7'b0001110;
        dig_seg[1] = 7'b0001000;
        dig_seg[2] = 7'b0100100;
        dig_seg[3] = 7'b1111001;
        for (int k = 0; k < 4; k++) show_cnt[k] = 0;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 16'h0, 4'h0);
            c = pos % 8;
            i = (pos / 8) % 4;
            e_an = 4'hF;
            if (c >= 2) e_an[i] = 1'b0;
            check_eq("frame_an", {12'h0, an}, {12'h0, e_an});
            check_eq("frame_seg", {9'h0, seg}, (c >= 2) ? {9'h0, dig_seg[i]} : 16'h007F);
            check_eq("frame_dp", {15'h0, dp}, (c >= 2 && i == 2) ? 16'h0 : 16'h1);
            if (an != 4'hF) show_cnt[i]++;
        end
        for (int k = 0; k < 4; k++) check_eq("show_cycles", 16'(show_cnt[k]), 16'd6);

        // Every hex glyph
        for (int h = 0; h < 16; h++) begin
            cycle(1'b1, {4{4'(h)}}, 4'h0);
            cycle(1'b0, 16'h0, 4'h0);
            found = 1'b0;
            for (int n = 0; n < 40 && !found; n++) begin
                if (pos % 8 >= 2 && (h != 0 || (pos / 8) % 4 == 0)) begin
                    check_eq("hex_seg", {9'h0, seg}, {9'h0, seg_tab[h]});
                    found = 1'b1;
                end else begin
                    cycle(1'b0, 16'h0, 4'h0);
                end
            end
            check_eq("hex_found", {15'h0, found}, 16'h1);
        end

        // Load coinciding with the idx 0->1 wrap edge
        cycle(1'b1, 16'h0000, 4'h0);
        while (pos % 32 != 6) cycle(1'b0, 16'h0, 4'h0);
        cycle(1'b1, 16'h0030, 4'h0);
        check_eq("wrap_last_d0", {12'h0, an}, 16'h000E);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("wrap_blank", {12'h0, an}, 16'h000F);
        cycle(1'b0, 16'h0, 4'h0);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("wrap_an", {12'h0, an}, 16'h000D);
        check_eq("wrap_seg", {9'h0, seg}, 16'h0030);

        // Leading-zero behaviour with 16'h0005
        cycle(1'b1, 16'h0005, 4'h0);
        while (pos % 32 != 31) cycle(1'b0, 16'h0, 4'h0);
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, 16'h0, 4'h0);
            c = pos % 8;
            i = (pos / 8) % 4;
            e_an = 4'hF;
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (c >= 2 && i == 0) e_an[0] = 1'b0;
`else
            if (c >= 2) e_an[i] = 1'b0;
`endif
            check_eq("lz_an", {12'h0, an}, {12'h0, e_an});
            if (e_an != 4'hF)
                check_eq("lz_seg", {9'h0, seg}, (i == 0) ? 16'h0012 : 16'h0040);
        end

        // Random loads over 1000 frames
        m_val = 16'h0005;
        m_dp = 4'h0;
        v_onehot = 0;
        v_blank = 0;
        v_seg = 0;
        for (int k = 0; k < 32000; k++) begin
            rl = ($urandom_range(0, 7) == 0);
            rv = 16'($urandom);
            rm = 4'($urandom);
            cycle(rl, rv, rm);
            c = pos % 8;
            i = (pos / 8) % 4;
            if ($countones(~an) > 1) v_onehot++;
            if (c < 2 && an != 4'hF) v_blank++;
            if (an != 4'hF) begin
                if (an[i] != 1'b0 || seg != seg_tab[m_val[4*i +: 4]] || dp != ~m_dp[i]) v_seg++;
            end
`ifndef SSD_LEADING_ZERO_BLANK_EN
            if (c >= 2 && an == 4'hF) v_seg++;
`endif
            if (rl) begin
                m_val = rv;
                m_dp = rm;
            end
        end
        check_eq("rand_onehot", 16'(v_onehot), 16'd0);
        check_eq("rand_blank", 16'(v_blank), 16'd0);
        check_eq("rand_digit", 16'(v_seg), 16'd0);

        // Reset during SHOW of digit 2
        cycle(1'b1, 16'h4321, 4'hF);
        while (pos % 32 != 19) cycle(1'b0, 16'h0, 4'h0);
        check_eq("pre_rst_an", {12'h0, an}, 16'h000B);
        reset = 1'b1;
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("mid_rst_an", {12'h0, an}, 16'h000F);
        check_eq("mid_rst_seg", {9'h0, seg}, 16'h007F);
        check_eq("mid_rst_dp", {15'h0, dp}, 16'h0001);
        reset = 1'b0;
        pos = -1;
        cycle(1'b0, 16'h0, 4'h0);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("restart_blank", {12'h0, an}, 16'h000F);
        cycle(1'b0, 16'h0, 4'h0);
        check_eq("restart_an", {12'h0, an}, 16'h000E);
        check_eq("restart_seg", {9'h0, seg}, 16'h0040);
        check_eq("restart_dp", {15'h0, dp}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
